// File: rtl/buffer_pkg.sv
// Shared constants and FSM encoding for the pattern-buffer load path.
package buffer_pkg;

  localparam int unsigned BUFFER_WIDTH = 8;
  localparam int unsigned BUFFER_SIZE  = 32;
  localparam int unsigned NO_BUFS      = 8;

  localparam logic [2:0] SEQ1ADR    = 3'd0;
  localparam logic [2:0] SEQ2ADR    = 3'd1;
  localparam logic [2:0] SEQCTRLADR = 3'd2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester select; a locked packet pins the grant to its owner.
module rr_arbiter #(
  parameter int unsigned NO_REQ = 2,
  parameter int unsigned PTR_W  = 1
) (
  input  logic [NO_REQ-1:0] req,
  input  logic              lock,
  input  logic [PTR_W-1:0]  last,
  output logic [NO_REQ-1:0] gnt
);

  int idx;

  always_comb begin
    gnt = '0;
    idx = 0;
    if (lock) begin
      // The owner of a locked packet is always the most recently granted one.
      gnt[last] = req[last];
    end else begin
      for (int i = 1; i <= int'(NO_REQ); i++) begin
        idx = (int'(last) + i) % int'(NO_REQ);
        if (gnt == '0 && req[idx]) begin
          gnt[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/buffer_load_arbiter.sv
// Arbitrates byte writes from several requesters onto the serial buffer-bank port,
// exchanging each byte MSB-first and returning the byte shifted out of the bank.
module buffer_load_arbiter #(
  parameter int unsigned BUFFER_WIDTH = buffer_pkg::BUFFER_WIDTH,
  parameter int unsigned NO_REQ       = 2
) (
  input  logic                                sclk,
  input  logic                                rst,
  input  logic [NO_REQ-1:0]                   req_valid,
  output logic [NO_REQ-1:0]                   req_ready,
  input  logic [NO_REQ-1:0][2:0]              req_addr,
  input  logic [NO_REQ-1:0][BUFFER_WIDTH-1:0] req_data,
  input  logic [NO_REQ-1:0]                   req_last,
  output logic [NO_REQ-1:0]                   grant,
  output logic                                sin,
  output logic                                ssel,
  output logic [2:0]                          saddr,
  input  logic                                sout,
  output logic [BUFFER_WIDTH-1:0]             rd_data,
  output logic                                rd_valid,
  output logic                                busy
);

  import buffer_pkg::*;

  localparam int unsigned CntW = $clog2(BUFFER_WIDTH) + 1;
  localparam int unsigned PtrW = (NO_REQ > 1) ? $clog2(NO_REQ) : 1;

  localparam logic [0:0] StIdle  = IDLE;
  localparam logic [0:0] StShift = SHIFT;

  logic [0:0]              state_q;
  logic [CntW-1:0]         cnt_q;
  logic [BUFFER_WIDTH-1:0] sh_q;
  logic [2:0]              saddr_q;
  logic [NO_REQ-1:0]       grant_q;
  logic                    lock_q;
  logic [PtrW-1:0]         last_q;
  logic [BUFFER_WIDTH-1:0] rd_data_q;
  logic                    rd_valid_q;

  logic [NO_REQ-1:0] arb_gnt;
  logic [PtrW-1:0]   sel_idx;
  logic              accept;
  logic              shift_done;

  rr_arbiter #(
    .NO_REQ (NO_REQ),
    .PTR_W  (PtrW)
  ) u_rr_arbiter (
    .req  (req_valid),
    .lock (lock_q),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < int'(NO_REQ); i++) begin
      if (arb_gnt[i]) begin
        sel_idx = PtrW'(i);
      end
    end
  end

  assign req_ready  = (state_q == StIdle && !rst) ? arb_gnt : '0;
  assign accept     = |(req_valid & req_ready);
  assign shift_done = (state_q == StShift) && (cnt_q == CntW'(BUFFER_WIDTH - 1));

  // One register serves both directions: data leaves at the MSB while sout enters at the LSB.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sh_q       <= '0;
      saddr_q    <= '0;
      grant_q    <= '0;
      lock_q     <= 1'b0;
      last_q     <= PtrW'(NO_REQ - 1);
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StShift;
            cnt_q   <= '0;
            sh_q    <= req_data[sel_idx];
            saddr_q <= req_addr[sel_idx];
            grant_q <= arb_gnt;
            last_q  <= sel_idx;
            lock_q  <= !req_last[sel_idx];
          end
        end
        StShift: begin
          sh_q  <= {sh_q[BUFFER_WIDTH-2:0], sout};
          cnt_q <= cnt_q + CntW'(1);
          if (shift_done) begin
            state_q    <= StIdle;
            rd_data_q  <= {sh_q[BUFFER_WIDTH-2:0], sout};
            rd_valid_q <= 1'b1;
            if (!lock_q) begin
              grant_q <= '0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ssel     = (state_q == StShift);
  assign sin      = ssel & sh_q[BUFFER_WIDTH-1];
  assign saddr    = saddr_q;
  assign grant    = grant_q;
  assign busy     = ssel | lock_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_buffer_load_arbiter.sv
// Scoreboard bench: directed requests with hand-computed bank exchanges.
module tb_buffer_load_arbiter;

  logic            sclk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_ready, req_last, grant;
  logic [1:0][2:0] req_addr;
  logic [1:0][7:0] req_data;
  logic            sin, ssel, sout, rd_valid, busy;
  logic [2:0]      saddr;
  logic [7:0]      rd_data;

  buffer_load_arbiter #(
    .BUFFER_WIDTH (8),
    .NO_REQ       (2)
  ) dut (
    .sclk      (sclk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_last  (req_last),
    .grant     (grant),
    .sin       (sin),
    .ssel      (ssel),
    .saddr     (saddr),
    .sout      (sout),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy)
  );

  always #5 sclk = ~sclk;

  typedef struct packed {logic [2:0] addr; logic [7:0] data; logic last;} item_t;
  typedef struct packed {logic [7:0] sent; logic [2:0] addr; logic [7:0] rd; logic [1:0] gnt;} exp_t;

  item_t q0[$];
  item_t q1[$];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  always @(posedge sclk) cyc <= cyc + 1;

  // Buffer bank model: each selected edge rotates sin in and presents its MSB on sout.
  logic [7:0] bank [8];
  logic       load_bank;
  assign sout = bank[saddr][7];
  always @(posedge sclk) begin
    if (load_bank) begin
      bank[0] <= 8'h77; bank[1] <= 8'h00; bank[2] <= 8'h55; bank[3] <= 8'h3C;
      bank[4] <= 8'h00; bank[5] <= 8'hC3; bank[6] <= 8'h12; bank[7] <= 8'h34;
    end else if (ssel) begin
      bank[saddr] <= {bank[saddr][6:0], sin};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_req(input int r, input logic [2:0] a, input logic [7:0] d, input logic l);
    item_t it;
    it = '{addr: a, data: d, last: l};
    if (r == 0) q0.push_back(it);
    else q1.push_back(it);
  endtask

  task automatic push_exp(input logic [7:0] s, input logic [2:0] a, input logic [7:0] rdv,
                          input logic [1:0] g);
    sb.push_back('{sent: s, addr: a, rd: rdv, gnt: g});
  endtask

  // Monitor: assemble each ssel frame, compare when rd_valid closes it.
  logic [7:0] f_bits;
  logic [2:0] f_addr;
  logic [1:0] f_grant;
  int         f_len = 0;
  logic       in_frame = 1'b0;
  logic       f_bad = 1'b0;
  logic       idle_bad = 1'b0;
  exp_t       e;

  always @(negedge sclk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (ssel) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          f_len    = 0;
          f_bits   = '0;
          f_addr   = saddr;
          f_grant  = grant;
          f_bad    = 1'b0;
        end
        f_bits = {f_bits[6:0], sin};
        f_len++;
        if (saddr !== f_addr || grant !== f_grant) f_bad = 1'b1;
      end else begin
        in_frame = 1'b0;
        if (sin !== 1'b0) idle_bad = 1'b1;
      end
      if (rd_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rd_valid: got pulse with rd_data 0x%0h, expected none", rd_data);
        end else begin
          e = sb.pop_front();
          check("sin_byte", 32'(f_bits), 32'(e.sent));
          check("saddr", 32'(f_addr), 32'(e.addr));
          check("rd_data", 32'(rd_data), 32'(e.rd));
          check("grant", 32'(f_grant), 32'(e.gnt));
          check("ssel_len", 32'(f_len), 32'd8);
          check("frame_stable", 32'(f_bad), 32'd0);
        end
      end
    end
  end

  task automatic drive_one(input int r);
    if (r == 0) begin
      if (q0.size() > 0) begin
        req_valid[0] = 1'b1; req_addr[0] = q0[0].addr;
        req_data[0]  = q0[0].data; req_last[0] = q0[0].last;
      end else begin
        req_valid[0] = 1'b0; req_data[0] = 8'hFF;
      end
    end else begin
      if (q1.size() > 0) begin
        req_valid[1] = 1'b1; req_addr[1] = q1[0].addr;
        req_data[1]  = q1[0].data; req_last[1] = q1[0].last;
      end else begin
        req_valid[1] = 1'b0; req_data[1] = 8'hFF;
      end
    end
  endtask

  // Presents queue heads each cycle; returns just after the final accept edge.
  task automatic run_phase(input int budget);
    int         last_acc;
    logic [1:0] acc;
    last_acc = -1;
    for (int n = 0; n < budget && (q0.size() > 0 || q1.size() > 0); n++) begin
      @(negedge sclk);
      drive_one(0);
      drive_one(1);
      #1 acc = req_valid & req_ready;
      @(posedge sclk);
      #1;
      if (acc != 2'b00) begin
        check("ready_onehot", 32'($countones(acc) == 1), 32'd1);
        if (last_acc >= 0) check("accept_spacing", 32'(cyc - last_acc), 32'd9);
        last_acc = cyc;
        if (acc[0]) void'(q0.pop_front());
        if (acc[1]) void'(q1.pop_front());
      end
    end
    if (q0.size() > 0 || q1.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got %0d requests pending, expected 0", q0.size() + q1.size());
      q0.delete();
      q1.delete();
    end
    req_valid = 2'b00;
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() > 0; n++) @(negedge sclk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge sclk);
    rst = 1'b1;
    req_valid = 2'b00;
    repeat (2) @(posedge sclk);
    #1 rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    @(negedge sclk);
    check({tag, "_ssel"}, 32'(ssel), 32'd0);
    check({tag, "_sin"}, 32'(sin), 32'd0);
    check({tag, "_saddr"}, 32'(saddr), 32'd0);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; load_bank = 1'b1;
    req_valid = 2'b00; req_last = 2'b00; req_addr = '0; req_data = '0;
    @(negedge sclk);
    req_valid = 2'b11;
    #1 check("ready_in_reset", 32'(req_ready), 32'd0);
    @(posedge sclk);
    #1 load_bank = 1'b0;
    @(posedge sclk);
    #1 rst = 1'b0; req_valid = 2'b00;
    check_reset("por");

    // Back-to-back single requester; last byte is overwritten to 0xFF mid-shift.
    push_req(0, 3'd0, 8'h01, 1'b1); push_exp(8'h01, 3'd0, 8'h77, 2'b01);
    push_req(0, 3'd0, 8'h02, 1'b1); push_exp(8'h02, 3'd0, 8'h01, 2'b01);
    push_req(0, 3'd3, 8'hA5, 1'b1); push_exp(8'hA5, 3'd3, 8'h3C, 2'b01);
    push_req(0, 3'd4, 8'h0F, 1'b1); push_exp(8'h0F, 3'd4, 8'h00, 2'b01);
    run_phase(100);
    drain();

    // Both requesters continuously valid from reset: grants alternate 0,1,0,1.
    do_reset();
    push_req(0, 3'd6, 8'h81, 1'b1); push_req(0, 3'd6, 8'h81, 1'b1);
    push_req(1, 3'd7, 8'h42, 1'b1); push_req(1, 3'd7, 8'h42, 1'b1);
    push_exp(8'h81, 3'd6, 8'h12, 2'b01); push_exp(8'h42, 3'd7, 8'h34, 2'b10);
    push_exp(8'h81, 3'd6, 8'h81, 2'b01); push_exp(8'h42, 3'd7, 8'h42, 2'b10);
    run_phase(100);
    drain();

    // Req1 two-byte packet locks out req0 until its last byte.
    do_reset();
    push_req(0, 3'd0, 8'h5A, 1'b1); push_req(0, 3'd0, 8'h6B, 1'b1);
    push_req(1, 3'd5, 8'h11, 1'b0); push_req(1, 3'd5, 8'h22, 1'b1);
    push_exp(8'h5A, 3'd0, 8'h02, 2'b01); push_exp(8'h11, 3'd5, 8'hC3, 2'b10);
    push_exp(8'h22, 3'd5, 8'h11, 2'b10); push_exp(8'h6B, 3'd0, 8'h5A, 2'b01);
    run_phase(100);
    drain();

    // Reset in the 4th shift cycle aborts; bank[2] keeps its 4 rotated bits (0x55 -> 0x59).
    do_reset();
    push_req(0, 3'd2, 8'h99, 1'b1);
    run_phase(20);
    repeat (3) @(posedge sclk);
    #1 rst = 1'b1;
    @(posedge sclk);
    #1 rst = 1'b0;
    check_reset("abort");
    repeat (12) @(negedge sclk);
    push_req(0, 3'd2, 8'hB1, 1'b1); push_exp(8'hB1, 3'd2, 8'h59, 2'b01);
    push_req(1, 3'd7, 8'hC2, 1'b1); push_exp(8'hC2, 3'd7, 8'h42, 2'b10);
    run_phase(100);
    drain();

    check("sin_zero_when_idle", 32'(idle_bad), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/buffer_load_arbiter.md
BUFFER_LOAD_ARBITER -- requirements
Module: buffer_load_arbiter

Interface
REQ-001 Parameter BUFFER_WIDTH, default 8, bits per serial transfer (one pattern byte).
REQ-002 Parameter NO_REQ, default 2, number of requesters (fixed at 2 for this revision).
REQ-003 sclk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  NO_REQ  per-requester byte-write request.
REQ-006 req_ready  output  NO_REQ  per-requester accept; transfer occurs when valid && ready on the same edge.
REQ-007 req_addr  input  NO_REQ x 3  target pattern buffer index 0..7 (0, 1 = sequence buffers; 2 = sequence control).
REQ-008 req_data  input  NO_REQ x BUFFER_WIDTH  byte to shift in.
REQ-009 req_last  input  NO_REQ  marks the final byte of a packet.
REQ-010 grant  output  NO_REQ  one-hot owner of the current or locked packet; 0 when unowned.
REQ-011 sin  output  1  serial data to the buffer bank.
REQ-012 ssel  output  1  serial enable to the buffer bank.
REQ-013 saddr  output  3  buffer select to the buffer bank.
REQ-014 sout  input  1  serial data returned from the buffer bank.
REQ-015 rd_data  output  BUFFER_WIDTH  byte shifted out during the last transfer.
REQ-016 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-017 busy  output  1  high while in SHIFT or while a packet is locked.

Function
REQ-018 FSM states SHALL be IDLE and SHIFT; IDLE->SHIFT on accept; SHIFT->IDLE after exactly BUFFER_WIDTH shift cycles.
REQ-019 req_ready SHALL be high only in IDLE and only for the selected requester; at most one bit high.
REQ-020 Selection in IDLE, unlocked: round-robin; with both valid, the requester not most recently granted wins; after reset, requester 0 wins ties.
REQ-021 Accepting a byte with req_last=0 SHALL lock grant to that requester; only it is served until a byte with req_last=1 is accepted, then the lock clears.
REQ-022 While locked, the other requester's req_valid SHALL be ignored even if the owner is idle.
REQ-023 Accept at edge T: cycles T+1..T+BUFFER_WIDTH SHALL have ssel=1, saddr=accepted req_addr, sin=req_data MSB first.
REQ-024 sout SHALL be sampled at each rising edge with ssel=1, MSB first, into a shift register.
REQ-025 rd_valid SHALL pulse in cycle T+BUFFER_WIDTH+1 with the captured byte; rd_data SHALL hold until the next pulse.
REQ-026 Earliest next accept SHALL be at edge T+BUFFER_WIDTH+1 (throughput one byte per BUFFER_WIDTH+1 cycles).
REQ-027 In IDLE, ssel and sin SHALL be 0; saddr SHALL hold its last driven value.
REQ-028 Request inputs SHALL be sampled only at accept; changes during SHIFT SHALL have no effect.
REQ-029 Shift counter SHALL be clog2(BUFFER_WIDTH)+1 bits and SHALL not wrap within a transfer.

Reset
REQ-030 On rst: state=IDLE, ssel=0, sin=0, saddr=0, grant=0, lock cleared, round-robin pointer favours requester 0, rd_data=0, rd_valid=0, busy=0, req_ready=0 that cycle.
REQ-031 rst during SHIFT SHALL abort next cycle: ssel=0, no rd_valid; the partially shifted buffer is not restored.

Structure
REQ-032 Package buffer_pkg SHALL hold BUFFER_WIDTH, BUFFER_SIZE=32, NO_BUFS=8, SEQ1ADR=0, SEQ2ADR=1, SEQCTRLADR=2, and the FSM state enum.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, lock, last-grant pointer in; one-hot grant out).
REQ-034 Serialiser and deserialiser SHALL share the single shift counter in the top module.

Verification
REQ-035 Req0 addr=3 data=0xA5 last=1, bank sout preloaded 0x3C -> ssel high 8 cycles, sin 1,0,1,0,0,1,0,1, saddr=3, rd_valid at T+9 with rd_data=0x3C.
REQ-036 Both valid, last=1, from reset -> req0 served first, req1 accepted at T+9; with both continuously valid, grants alternate 0,1,0,1.
REQ-037 Req1 packet 0x11(last=0), 0x22(last=1) to addr 5 with req0 valid throughout -> both req1 bytes served before any req0 byte; grant=2'b10 throughout.
REQ-038 rst asserted at 4th shift cycle -> ssel=0 next cycle, no rd_valid, all outputs at reset values, req0 wins next tie.
REQ-039 req_data changed to 0xFF mid-SHIFT after accepting 0x0F -> sin still 0,0,0,0,1,1,1,1.
REQ-040 Back-to-back req0 bytes to addr 0 -> accepts exactly 9 cycles apart, ssel low exactly one cycle between transfers.
